// File: rtl/maze_job_sched.sv
// Round-robin job scheduler in front of the 15x15 maze solver.
// Grants one requester at a time and streams its maze bits into the solver.
// It then watches the solver's path output, measures the path length and
// reports a one-cycle done pulse with a status code.
module maze_job_sched #(
  parameter  int NREQ      = 2,
  parameter  int MAZE_BITS = 225,
  parameter  int TIMEOUT   = 4095,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] s_valid,
  input  logic [NREQ-1:0] s_bit,
  output logic [NREQ-1:0] gnt,
  output logic            s_ready,
  output logic            ms_in_valid,
  output logic            ms_maze,
  input  logic            ms_out_valid,
  input  logic            ms_maze_not_valid,
  input  logic [3:0]      ms_out_x,
  input  logic [3:0]      ms_out_y,
  output logic            done,
  output logic [IDW-1:0]  done_id,
  output logic [1:0]      done_status,
  output logic [7:0]      path_len,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0]  ST_OK      = 2'd0;
  localparam logic [1:0]  ST_NOPATH  = 2'd1;
  localparam logic [1:0]  ST_TIMEOUT = 2'd2;
  localparam logic [1:0]  ST_PATHERR = 2'd3;
  localparam logic [7:0]  BIT_LAST   = 8'(MAZE_BITS - 1);
  localparam logic [11:0] TMO_LAST   = 12'(TIMEOUT - 1);

  state_t          state_r, state_nxt_s;
  logic [IDW-1:0]  gid_r, rr_ptr_r, pick_s, rr_nxt_s;
  logic            pick_vld_s, start_s, accept_s, out_hit_s;
  logic [NREQ-1:0] gnt_r;
  logic [7:0]      bit_cnt_r, plen_cnt_r, path_len_r;
  logic [11:0]     tmo_cnt_r;
  logic [3:0]      last_x_r, last_y_r;
  logic            nopath_r;
  logic            ms_in_valid_r, ms_maze_r;
  logic            done_r, busy_r;
  logic [IDW-1:0]  done_id_r;
  logic [1:0]      done_status_r, status_s;

  // Round-robin pick: first set req bit at or after rr_ptr, wrapping around.
  always_comb begin : arb_comb
    int idx;
    idx        = 0;
    pick_vld_s = 1'b0;
    pick_s     = {IDW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!pick_vld_s && req[IDW'(idx)]) begin
        pick_vld_s = 1'b1;
        pick_s     = IDW'(idx);
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Handshake qualifiers and the status a job would finish with right now.
  always_comb begin
    start_s   = (state_r == S_IDLE) && pick_vld_s;
    accept_s  = (state_r == S_LOAD) && s_valid[gid_r];
    out_hit_s = ((state_r == S_WAIT) || (state_r == S_STREAM)) && ms_out_valid;
    rr_nxt_s  = (gid_r == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gid_r + IDW'(1);
    if (state_r == S_WAIT) begin
      status_s = ST_TIMEOUT;
    end else if (nopath_r) begin
      status_s = ST_NOPATH;
    end else if ((last_x_r != 4'd1) || (last_y_r != 4'd1)) begin
      status_s = ST_PATHERR;
    end else begin
      status_s = ST_OK;
    end
  end

  // Next-state logic of the job sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pick_vld_s) state_nxt_s = S_LOAD;
        else            state_nxt_s = S_IDLE;
      end
      S_LOAD: begin
        if (accept_s && (bit_cnt_r == BIT_LAST)) state_nxt_s = S_WAIT;
        else                                     state_nxt_s = S_LOAD;
      end
      S_WAIT: begin
        if (ms_out_valid)                state_nxt_s = S_STREAM;
        else if (tmo_cnt_r == TMO_LAST)  state_nxt_s = S_DONE;
        else                             state_nxt_s = S_WAIT;
      end
      S_STREAM: begin
        if (!ms_out_valid) state_nxt_s = S_DONE;
        else               state_nxt_s = S_STREAM;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Job ownership: grant captured at arbitration, released after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gid_r    <= {IDW{1'b0}};
      gnt_r    <= {NREQ{1'b0}};
      rr_ptr_r <= {IDW{1'b0}};
    end else if (start_s) begin
      gid_r <= pick_s;
      gnt_r <= {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
    end else if (state_r == S_DONE) begin
      gnt_r    <= {NREQ{1'b0}};
      rr_ptr_r <= rr_nxt_s;
    end
  end

  // Maze bit path into the solver, one cycle behind acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r     <= 8'd0;
      ms_in_valid_r <= 1'b0;
      ms_maze_r     <= 1'b0;
    end else begin
      ms_in_valid_r <= accept_s;
      ms_maze_r     <= accept_s ? s_bit[gid_r] : 1'b0;
      if (start_s)       bit_cnt_r <= 8'd0;
      else if (accept_s) bit_cnt_r <= bit_cnt_r + 8'd1;
    end
  end

  // Solver output monitor: timeout, path length, last coordinate, no-path flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r  <= 12'd0;
      plen_cnt_r <= 8'd0;
      last_x_r   <= 4'd0;
      last_y_r   <= 4'd0;
      nopath_r   <= 1'b0;
    end else if (start_s) begin
      tmo_cnt_r  <= 12'd0;
      plen_cnt_r <= 8'd0;
      last_x_r   <= 4'd0;
      last_y_r   <= 4'd0;
      nopath_r   <= 1'b0;
    end else begin
      if ((state_r == S_WAIT) && !ms_out_valid) tmo_cnt_r <= tmo_cnt_r + 12'd1;
      if (out_hit_s) begin
        if (plen_cnt_r != 8'hFF) plen_cnt_r <= plen_cnt_r + 8'd1;
        last_x_r <= ms_out_x;
        last_y_r <= ms_out_y;
        nopath_r <= nopath_r | ms_maze_not_valid;
      end
    end
  end

  // Result registers: done pulse plus status/length held until the next job ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r        <= 1'b0;
      done_id_r     <= {IDW{1'b0}};
      done_status_r <= 2'd0;
      path_len_r    <= 8'd0;
      busy_r        <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == S_DONE);
      busy_r <= (state_nxt_s != S_IDLE);
      if (state_nxt_s == S_DONE) begin
        done_id_r     <= gid_r;
        done_status_r <= status_s;
        path_len_r    <= plen_cnt_r;
      end
    end
  end

  assign gnt         = gnt_r;
  assign s_ready     = accept_s;
  assign ms_in_valid = ms_in_valid_r;
  assign ms_maze     = ms_maze_r;
  assign done        = done_r;
  assign done_id     = done_id_r;
  assign done_status = done_status_r;
  assign path_len    = path_len_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_maze_job_sched.sv
// Self-checking bench for maze_job_sched: directed jobs plus randomized jobs,
// with expectations taken from a job-level model (round-robin owner, bit
// count, solver stream outcome).
module tb_maze_job_sched;
  localparam int NREQ = 2;
  localparam int MB   = 225;
  localparam int TO   = 4095;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, s_valid, s_bit, gnt;
  logic       s_ready, ms_in_valid, ms_maze;
  logic       ms_out_valid, ms_maze_not_valid;
  logic [3:0] ms_out_x, ms_out_y;
  logic       done;
  logic       done_id;
  logic [1:0] done_status;
  logic [7:0] path_len;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int rr       = 0;

  maze_job_sched #(.NREQ(NREQ), .MAZE_BITS(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .s_valid(s_valid), .s_bit(s_bit),
    .gnt(gnt), .s_ready(s_ready), .ms_in_valid(ms_in_valid), .ms_maze(ms_maze),
    .ms_out_valid(ms_out_valid), .ms_maze_not_valid(ms_maze_not_valid),
    .ms_out_x(ms_out_x), .ms_out_y(ms_out_y), .done(done), .done_id(done_id),
    .done_status(done_status), .path_len(path_len), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner chosen by round robin: first requesting index at or after p.
  function automatic int pick(input logic [1:0] r, input int p);
    int rv;
    rv = int'(r);
    for (int i = 0; i < NREQ; i++) begin
      if (((rv >> ((p + i) % NREQ)) & 1) == 1) return (p + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic idle_inputs();
    req = 2'b00; s_valid = 2'b00; s_bit = 2'b00;
    ms_out_valid = 1'b0; ms_maze_not_valid = 1'b0; ms_out_x = 4'd0; ms_out_y = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    rr = 0;
    tick();
  endtask

  // One complete job from an IDLE cycle to the IDLE cycle after DONE.
  // gap_mode 0: no gaps, 1: alternate valid/gap, 2: random gaps.
  // n_valid 0: solver stays silent (timeout). np_sel 0: none, 1: every cycle, 2: one cycle.
  task automatic run_job(input logic [1:0] rq, input logic [1:0] rq_mid, input int gap_mode,
                         input int n_valid, input int np_sel, input logic [3:0] lx,
                         input logic [3:0] ly);
    int g, acc, cyc, lat_err, sr_err, inv_cnt, np_at, early, exp_len, exp_st;
    logic gi, v, b;
    req = rq; ms_out_valid = 1'b1; ms_maze_not_valid = 1'b1;
    g  = pick(rq, rr);
    gi = 1'(g);
    tick();
    chk("gnt_load", 32'(gnt), 32'(1) << g);
    chk("busy_load", 32'(busy), 1);
    req = rq_mid;
    acc = 0; cyc = 0; lat_err = 0; sr_err = 0; inv_cnt = 0;
    while (acc < MB && cyc < 4 * MB) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = ((cyc % 2) == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      b = 1'($urandom);
      s_valid = 2'($urandom); s_bit = 2'($urandom);
      s_valid[gi] = v; s_bit[gi] = b;
      ms_out_valid = 1'($urandom); ms_maze_not_valid = 1'b1;
      ms_out_x = 4'($urandom); ms_out_y = 4'($urandom);
      #1;
      if (s_ready !== v) sr_err++;
      tick();
      if ((ms_in_valid !== v) || (v && (ms_maze !== b))) lat_err++;
      if (ms_in_valid === 1'b1) inv_cnt++;
      if (v) acc++;
      cyc++;
    end
    if (gap_mode == 0) chk("load_cycles", 32'(cyc), MB);
    else if (gap_mode == 1) chk("load_cycles_gap", 32'(cyc), 2 * MB - 1);
    chk("in_valid_count", 32'(inv_cnt), MB);
    chk("maze_bit_order", 32'(lat_err), 0);
    chk("s_ready_load", 32'(sr_err), 0);
    // First WAIT cycle: granted requester offers more bits, none may be taken.
    s_valid = 2'b11; s_bit = 2'b11; ms_out_valid = 1'b0; ms_maze_not_valid = 1'b0;
    #1;
    chk("no_ready_wait", 32'(s_ready), 0);
    tick();
    chk("no_extra_bit", 32'(ms_in_valid), 0);
    s_valid = 2'b00;
    if (n_valid == 0) begin
      repeat (TO - 2) tick();
      chk("no_done_before_timeout", 32'(done), 0);
      tick();
      exp_st = 2; exp_len = 0;
    end else begin
      repeat ($urandom_range(0, 5)) tick();
      np_at = $urandom_range(0, n_valid - 1);
      early = 0;
      for (int i = 0; i < n_valid; i++) begin
        ms_out_valid = 1'b1;
        ms_maze_not_valid = (np_sel == 1) || ((np_sel == 2) && (i == np_at));
        if (i == n_valid - 1) begin
          ms_out_x = lx; ms_out_y = ly;
        end else begin
          ms_out_x = 4'($urandom); ms_out_y = 4'($urandom);
        end
        tick();
        if (done !== 1'b0) early++;
      end
      chk("no_done_stream", 32'(early), 0);
      ms_out_valid = 1'b0; ms_maze_not_valid = 1'b0;
      ms_out_x = 4'($urandom); ms_out_y = 4'($urandom);
      tick();
      exp_len = (n_valid > 255) ? 255 : n_valid;
      if (np_sel != 0) exp_st = 1;
      else if ((lx != 4'd1) || (ly != 4'd1)) exp_st = 3;
      else exp_st = 0;
    end
    chk("done_pulse", 32'(done), 1);
    chk("done_id", 32'(done_id), g);
    chk("done_status", 32'(done_status), exp_st);
    chk("path_len", 32'(path_len), exp_len);
    chk("gnt_in_done", 32'(gnt), 32'(1) << g);
    ms_out_valid = 1'($urandom); ms_maze_not_valid = 1'b1;
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("gnt_cleared", 32'(gnt), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("status_held", 32'(done_status), exp_st);
    chk("path_len_held", 32'(path_len), exp_len);
    rr = (g + 1) % NREQ;
  endtask

  initial begin : stim
    int g, dn, n, np;
    logic [1:0] rq;
    logic [3:0] lx, ly;
    rst_n = 1'b1;
    do_reset();
    // Reset state, with the requesters offering bits while nothing is granted.
    s_valid = 2'b11;
    #1;
    chk("rst_s_ready", 32'(s_ready), 0);
    s_valid = 2'b00;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_in_valid", 32'(ms_in_valid), 0);
    chk("rst_maze", 32'(ms_maze), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_status", 32'(done_status), 0);
    chk("rst_path_len", 32'(path_len), 0);
    chk("rst_busy", 32'(busy), 0);

    // Single requester, gapless load, good path.
    run_job(2'b01, 2'b01, 0, 20, 0, 4'd1, 4'd1);

    // Both requesting after reset; second job drops req[1] mid-job; then pointer wraps.
    do_reset();
    run_job(2'b11, 2'b11, 0, 15, 0, 4'd1, 4'd1);
    run_job(2'b11, 2'b01, 0, 12, 0, 4'd1, 4'd1);
    run_job(2'b01, 2'b01, 0, 9, 0, 4'd1, 4'd1);

    // Alternating valid/gap load.
    run_job(2'b10, 2'b10, 1, 30, 0, 4'd1, 4'd1);

    // Silent solver: timeout.
    run_job(2'b01, 2'b00, 0, 0, 0, 4'd0, 4'd0);

    // No-path for 3 cycles (even ending at (1,1)), then wrong end point.
    run_job(2'b11, 2'b11, 0, 3, 1, 4'd1, 4'd1);
    run_job(2'b11, 2'b11, 0, 7, 0, 4'd2, 4'd1);

    // Path length saturation.
    run_job(2'b10, 2'b10, 0, 300, 0, 4'd1, 4'd1);

    // Randomized jobs.
    repeat (6) begin
      rq = 2'($urandom_range(1, 3));
      n  = $urandom_range(1, 40);
      np = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        lx = 4'd1; ly = 4'd1;
      end else begin
        lx = 4'($urandom); ly = 4'($urandom);
      end
      run_job(rq, rq, 2, n, np, lx, ly);
    end

    // Reset in the middle of a load, then a fresh full job.
    req = 2'b01;
    g = pick(req, rr);
    tick();
    chk("t6_gnt", 32'(gnt), 32'(1) << g);
    for (int i = 0; i < 100; i++) begin
      s_valid = 2'b11; s_bit = 2'($urandom);
      tick();
    end
    chk("t6_in_valid_before_rst", 32'(ms_in_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_in_valid_rst", 32'(ms_in_valid), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_gnt_rst", 32'(gnt), 0);
    dn = 0;
    repeat (3) begin
      tick();
      if ((done !== 1'b0) || (ms_in_valid !== 1'b0)) dn++;
    end
    chk("t6_quiet_in_reset", 32'(dn), 0);
    idle_inputs();
    rst_n = 1'b1;
    rr = 0;
    tick();
    chk("t6_no_done_after_rst", 32'(done), 0);
    run_job(2'b10, 2'b10, 0, 11, 0, 4'd1, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
